mem_copy_dma: RTL

Block-copy engine that acts as the initiator on the single-port memory interface (addr / r_en / w_en / data_in / data_out). On a start request it reads `len` consecutive words starting at `src_addr` and writes them to consecutive words starting at `dst_addr`, one word per two clock cycles. It sits between the control logic and the memory, and is the only master driving the memory port while busy.

---
 rtl/mem_copy_dma.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_copy_dma.sv
// Block-copy engine: reads len words from src_addr and writes them to dst_addr,
// one word every two cycles, as sole master of a single-port memory.
module mem_copy_dma #(
  parameter int ADDR_LEN  = 8,
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_LEN-1:0]  src_addr,
  input  logic [ADDR_LEN-1:0]  dst_addr,
  input  logic [ADDR_LEN-1:0]  len,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_LEN-1:0]  mem_addr,
  output logic                 mem_r_en,
  output logic                 mem_w_en,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_LEN-1:0] ONE = {{(ADDR_LEN-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [ADDR_LEN-1:0]  src_q, src_d, dst_q, dst_d, rem_q, rem_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 r_en_q, r_en_d, w_en_q, w_en_d;
  logic [ADDR_LEN-1:0]  addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;

  // Next-state, datapath updates, and the output values for the next cycle
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    data_d  = data_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    r_en_d  = 1'b0;
    w_en_d  = 1'b0;
    addr_d  = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          rem_d   = len;
          state_d = (len != '0) ? S_READ : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        data_d  = mem_rdata;
        src_d   = src_q + ONE;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        dst_d = dst_q + ONE;
        rem_d = rem_q - ONE;
        if (rem_q > ONE) begin
          state_d = S_READ;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so decode them from the state being entered
    case (state_d)
      S_READ: begin
        busy_d = 1'b1;
        r_en_d = 1'b1;
        addr_d = src_d;
      end
      S_WRITE: begin
        busy_d = 1'b1;
        w_en_d = 1'b1;
        addr_d = dst_d;
      end
      S_DONE:  done_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
    wdata_d = data_d;
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_en_q  <= 1'b0;
      w_en_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      r_en_q  <= r_en_d;
      w_en_q  <= w_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_addr  = addr_q;
  assign mem_r_en  = r_en_q;
  assign mem_w_en  = w_en_q;
  assign mem_wdata = wdata_q;

endmodule
